// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr} pairs between instruction memory and decode.
// Optional same-cycle bypass when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  pc_mem_q    [DEPTH];
    logic [XLEN-1:0]  instr_mem_q [DEPTH];

    logic full_c, empty_c, byp_c, push_c, pop_c, wr_en_c, rd_en_c;

    // Handshake, bypass and storage-enable decode
    always_comb begin
        full_c  = (count_q == CNT_W'(DEPTH));
        empty_c = (count_q == '0);
        in_ready = rst_n && !full_c;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp_c = rst_n && empty_c && in_valid && !flush;
`else
        byp_c = 1'b0;
`endif
        out_valid = rst_n && !flush && (!empty_c || byp_c);
        push_c    = in_valid && in_ready && !flush;
        pop_c     = out_valid && out_ready;
        // A bypassed entry consumed the same cycle never touches storage
        wr_en_c   = push_c && !(byp_c && out_ready);
        rd_en_c   = pop_c && !byp_c;

        out_pc    = '0;
        out_instr = '0;
        if (out_valid) begin
            if (byp_c) begin
                out_pc    = in_pc;
                out_instr = in_instr;
            end else begin
                out_pc    = pc_mem_q[rd_ptr_q];
                out_instr = instr_mem_q[rd_ptr_q];
            end
        end
        count = count_q;
    end

    // Next-state for pointers and occupancy
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (wr_en_c && !rd_en_c)      count_d = count_q + CNT_W'(1);
            else if (rd_en_c && !wr_en_c) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset; occupancy alone qualifies its contents
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instr;
        end
    end

endmodule
